// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory handshake bundle between the datapath and pipeline_ctrl.
// Latency: none, wires only. The datapath side is master, pipeline_ctrl is slave.
// Backpressure: imem_ready and dmem_ready are the only ready inputs; the en*/clr* outputs act as flow control.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             stallF;
    logic             stallD;
    logic             flushE;
    logic             pcsrcD;
    logic             jumpD;
    logic             imem_ready;
    logic             dmem_req_M;
    logic             dmem_ready;
    logic             enF;
    logic             enD;
    logic             clrD;
    logic             enE;
    logic             clrE;
    logic             enM;
    logic             enW;
    logic             validE;
    logic             validM;
    logic             validW;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output stallF, stallD, flushE, pcsrcD, jumpD, imem_ready, dmem_req_M, dmem_ready,
        input  enF, enD, clrD, enE, clrE, enM, enW, validE, validM, validW, mem_err,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  stallF, stallD, flushE, pcsrcD, jumpD, imem_ready, dmem_req_M, dmem_ready,
        output enF, enD, clrD, enE, clrE, enM, enW, validE, validM, validW, mem_err,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Per-stage enables/clears and valid tracking for the 5-stage pipe; optional perf counters under PIPELINE_PERF_CNT_EN.
// Latency: enables and clears are combinational; valids, mem_err and counters update one clock later.
// Backpressure: a data-memory wait freezes the whole pipe and overrides hazard stalls, imem waits and redirects.
module pipeline_ctrl #(
    parameter int DMEM_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    pipeline_ctrl_if.slave bus
);
    localparam int TW = $clog2(DMEM_TIMEOUT + 1);

    typedef enum logic {RUN, DWAIT} state_t;

    state_t        state;
    state_t        stateNext;
    logic          freeze;
    logic          enF, enD, clrD, enE, clrE, enM, enW;
    logic          validD, validE, validM, validW;
    logic          memErr;
    logic [TW-1:0] waitCnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= stateNext;
    end

    // The first miss cycle freezes while still in RUN, so no instruction slips past M.
    always_comb begin
        stateNext = state;
        freeze    = 1'b0;
        case (state)
            RUN: begin
                if (validM && bus.dmem_req_M && !bus.dmem_ready) begin
                    stateNext = DWAIT;
                    freeze    = 1'b1;
                end
            end
            DWAIT: begin
                if (bus.dmem_ready) stateNext = RUN;
                else                freeze    = 1'b1;
            end
            default: stateNext = RUN;
        endcase
    end

    always_comb begin
        enF  = 1'b0;
        enD  = 1'b0;
        clrD = 1'b0;
        enE  = 1'b0;
        clrE = 1'b0;
        enM  = 1'b0;
        enW  = 1'b0;
        if (!reset_n) begin
            clrD = 1'b1;
            clrE = 1'b1;
        end else if (!freeze) begin
            enF  = !bus.stallF && bus.imem_ready;
            enD  = !bus.stallD;
            // A held D keeps the branch, so the redirect is simply retried next cycle.
            clrD = !bus.stallD && (bus.pcsrcD || bus.jumpD || !bus.imem_ready);
            enE  = 1'b1;
            clrE = bus.flushE;
            enM  = 1'b1;
            enW  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            validD <= 1'b0;
            validE <= 1'b0;
            validM <= 1'b0;
            validW <= 1'b0;
        end else begin
            if (enD) validD <= !clrD;
            if (enE) validE <= !clrE && validD;
            if (enM) validM <= validE;
            if (enW) validW <= validM;
        end
    end

    // The timeout only flags the hang; the wait itself is never abandoned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waitCnt <= '0;
            memErr  <= 1'b0;
        end else if (state == DWAIT) begin
            if (waitCnt != TW'(DMEM_TIMEOUT)) waitCnt <= waitCnt + TW'(1);
            if (waitCnt == TW'(DMEM_TIMEOUT - 1)) memErr <= 1'b1;
        end else begin
            waitCnt <= '0;
        end
    end

`ifdef PIPELINE_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (!enF && stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
            if ((clrD || clrE) && flushCnt != '1) flushCnt <= flushCnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stallCnt;
    assign bus.flush_cnt = flushCnt;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

    assign bus.enF     = enF;
    assign bus.enD     = enD;
    assign bus.clrD    = clrD;
    assign bus.enE     = enE;
    assign bus.clrE    = clrE;
    assign bus.enM     = enM;
    assign bus.enW     = enW;
    assign bus.validE  = validE;
    assign bus.validM  = validM;
    assign bus.validW  = validW;
    assign bus.mem_err = memErr;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a cycle model checked every negedge plus hand-computed literal checks.
// DMEM_TIMEOUT is overridden to 4 so the timeout path is reachable in a few cycles.
module tb_pipeline_ctrl;
    localparam int TIMEOUT = 4;
    localparam int MAXC    = (1 << 16) - 1;

    typedef struct packed {
        logic enF, enD, clrD, enE, clrE, enM, enW;
    } ctl_t;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    pipeline_ctrl_if #(.CNT_W(16)) bus ();

    pipeline_ctrl #(.DMEM_TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Model state: which instruction slots are live, whether we wait on dmem and for how long.
    bit mValidD = 0, mValidE = 0, mValidM = 0, mValidW = 0;
    bit mWaiting = 0, mErr = 0;
    int mWaitCycles = 0, mStall = 0, mFlush = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ctl_t predict();
        ctl_t c;
        bit   hold;
        c = '0;
        if (!reset_n) begin
            c.clrD = 1'b1;
            c.clrE = 1'b1;
            return c;
        end
        hold = (mWaiting || (mValidM && bus.dmem_req_M)) && !bus.dmem_ready;
        if (hold) return c;
        c.enF  = !bus.stallF && bus.imem_ready;
        c.enD  = !bus.stallD;
        c.clrD = !bus.stallD && (bus.pcsrcD || bus.jumpD || !bus.imem_ready);
        c.enE  = 1'b1;
        c.clrE = bus.flushE;
        c.enM  = 1'b1;
        c.enW  = 1'b1;
        return c;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        ctl_t c;
        if (!reset_n) begin
            mValidD <= 0; mValidE <= 0; mValidM <= 0; mValidW <= 0;
            mWaiting <= 0; mWaitCycles <= 0; mErr <= 0;
            mStall <= 0; mFlush <= 0;
        end else begin
            c = predict();
            if (c.enD) mValidD <= !c.clrD;
            if (c.enE) mValidE <= !c.clrE && mValidD;
            if (c.enM) mValidM <= mValidE;
            if (c.enW) mValidW <= mValidM;
            if (mWaiting) begin
                mWaiting    <= !bus.dmem_ready;
                mWaitCycles <= mWaitCycles + 1;
                if (mWaitCycles + 1 >= TIMEOUT) mErr <= 1;
            end else begin
                mWaiting    <= mValidM && bus.dmem_req_M && !bus.dmem_ready;
                mWaitCycles <= 0;
            end
            if (!c.enF && mStall < MAXC) mStall <= mStall + 1;
            if ((c.clrD || c.clrE) && mFlush < MAXC) mFlush <= mFlush + 1;
        end
    end

    always @(negedge clk) begin
        ctl_t c;
        int   expStall, expFlush;
        c = predict();
`ifdef PIPELINE_PERF_CNT_EN
        expStall = mStall;
        expFlush = mFlush;
`else
        expStall = 0;
        expFlush = 0;
`endif
        chk("enF",       32'(bus.enF),     32'(c.enF));
        chk("enD",       32'(bus.enD),     32'(c.enD));
        chk("clrD",      32'(bus.clrD),    32'(c.clrD));
        chk("enE",       32'(bus.enE),     32'(c.enE));
        chk("clrE",      32'(bus.clrE),    32'(c.clrE));
        chk("enM",       32'(bus.enM),     32'(c.enM));
        chk("enW",       32'(bus.enW),     32'(c.enW));
        chk("validE",    32'(bus.validE),  32'(mValidE));
        chk("validM",    32'(bus.validM),  32'(mValidM));
        chk("validW",    32'(bus.validW),  32'(mValidW));
        chk("mem_err",   32'(bus.mem_err), 32'(mErr));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(expStall));
        chk("flush_cnt", 32'(bus.flush_cnt), 32'(expFlush));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.stallF     = 1'b0;
        bus.stallD     = 1'b0;
        bus.flushE     = 1'b0;
        bus.pcsrcD     = 1'b0;
        bus.jumpD      = 1'b0;
        bus.imem_ready = 1'b1;
        bus.dmem_req_M = 1'b0;
        bus.dmem_ready = 1'b1;
        tick(); tick();
        #2;
        chk("rst enF",    32'(bus.enF),     0);
        chk("rst clrD",   32'(bus.clrD),    1);
        chk("rst clrE",   32'(bus.clrE),    1);
        chk("rst validW", 32'(bus.validW),  0);
        chk("rst memerr", 32'(bus.mem_err), 0);

        // Fill: one new stage valid per clock.
        tick(); reset_n = 1'b1;
        #2;
        chk("fill enF",  32'(bus.enF),  1);
        chk("fill clrD", 32'(bus.clrD), 0);
        tick(); tick(); #2;
        chk("fill validE", 32'(bus.validE), 1);
        chk("fill validM", 32'(bus.validM), 0);
        tick(); #2;
        chk("fill validM2", 32'(bus.validM), 1);
        tick(); #2;
        chk("fill validW", 32'(bus.validW), 1);

        // Load-use style stall with bubble into E.
        tick();
        bus.stallF = 1'b1; bus.stallD = 1'b1; bus.flushE = 1'b1;
        #2;
        chk("stall enF",  32'(bus.enF),  0);
        chk("stall enD",  32'(bus.enD),  0);
        chk("stall clrE", 32'(bus.clrE), 1);
        tick();
        bus.stallF = 1'b0; bus.stallD = 1'b0; bus.flushE = 1'b0;
        #2;
        chk("bubble validE", 32'(bus.validE), 0);
        chk("resume enF",    32'(bus.enF),    1);
        tick(); #2;
        chk("held validD", 32'(bus.validE), 1);

        // Redirect, then redirect under stall, then flushE with imem miss.
        tick(); bus.pcsrcD = 1'b1;
        #2; chk("redir clrD", 32'(bus.clrD), 1);
        tick(); bus.pcsrcD = 1'b0;
        tick(); #2;
        chk("redir validE", 32'(bus.validE), 0);
        tick(); bus.pcsrcD = 1'b1; bus.stallD = 1'b1;
        #2;
        chk("redir stall clrD", 32'(bus.clrD), 0);
        chk("redir stall enD",  32'(bus.enD),  0);
        tick(); bus.pcsrcD = 1'b0; bus.stallD = 1'b0;
        bus.flushE = 1'b1; bus.imem_ready = 1'b0;
        #2;
        chk("dual clrE", 32'(bus.clrE), 1);
        chk("dual clrD", 32'(bus.clrD), 1);
        chk("dual enF",  32'(bus.enF),  0);
        tick(); bus.flushE = 1'b0; bus.imem_ready = 1'b1;
        repeat (4) tick();

        // Multi-cycle dmem access: three frozen cycles, then the ready cycle runs.
        bus.dmem_req_M = 1'b1; bus.dmem_ready = 1'b0;
        #2; chk("dw a enM", 32'(bus.enM), 0); chk("dw a enF", 32'(bus.enF), 0);
        tick(); #2; chk("dw b enW", 32'(bus.enW), 0);
        tick(); #2; chk("dw c enE", 32'(bus.enE), 0);
        tick(); bus.dmem_ready = 1'b1;
        #2; chk("dw d enM", 32'(bus.enM), 1); chk("dw d enF", 32'(bus.enF), 1);
        tick(); bus.dmem_req_M = 1'b0;
        #2; chk("dw memerr", 32'(bus.mem_err), 0);

        // Timeout after four cycles in DWAIT; sticky past completion.
        tick(); bus.dmem_req_M = 1'b1; bus.dmem_ready = 1'b0;
        repeat (4) tick();
        #2; chk("to before", 32'(bus.mem_err), 0);
        tick(); #2; chk("to set", 32'(bus.mem_err), 1);
        bus.dmem_ready = 1'b1;
        tick(); bus.dmem_req_M = 1'b0; bus.dmem_ready = 1'b0;
        #2; chk("to sticky", 32'(bus.mem_err), 1);
        tick(); bus.dmem_req_M = 1'b1;
        tick(); tick();
        #2; reset_n = 1'b0;
        #1;
        chk("rdw validE", 32'(bus.validE),  0);
        chk("rdw validM", 32'(bus.validM),  0);
        chk("rdw validW", 32'(bus.validW),  0);
        chk("rdw memerr", 32'(bus.mem_err), 0);
        chk("rdw clrE",   32'(bus.clrE),    1);
        tick(); tick(); reset_n = 1'b1;
        #2; chk("rdw run enF", 32'(bus.enF), 1);

        // Five imem-miss cycles: each stalls the PC and bubbles D.
        tick(); bus.dmem_req_M = 1'b0; bus.dmem_ready = 1'b1; bus.imem_ready = 1'b0;
        repeat (5) tick();
        bus.imem_ready = 1'b1;
        #2;
`ifdef PIPELINE_PERF_CNT_EN
        chk("perf stall", 32'(bus.stall_cnt), 5);
        chk("perf flush", 32'(bus.flush_cnt), 5);
`else
        chk("perf stall", 32'(bus.stall_cnt), 0);
        chk("perf flush", 32'(bus.flush_cnt), 0);
`endif
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
